// File: rtl/avr_spi_pkg.sv
// Shared types and helpers for the AVR SPI slave path.
// Includes the SCK-domain frame FSM states and the first-bit select used at frame start.
package avr_spi_pkg;

  localparam int SPI_DATA_W_MAX = 32;
  localparam int SPI_IDX_W      = $clog2(SPI_DATA_W_MAX);

  typedef struct packed {
    logic spe;
    logic mstr;
    logic dord;
    logic cpha;
  } spcr_t;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SHIFT
  } sckd_frame_state_e;

  // Bit that leaves the shifter first for a word of data_w bits.
  function automatic logic first_bit(input logic [SPI_DATA_W_MAX-1:0] word,
                                     input logic                      dord,
                                     input int                        data_w);
    return dord ? word[0] : word[SPI_IDX_W'(data_w - 1)];
  endfunction

endpackage

// File: rtl/avr_spi_sckd_shreg.sv
// Single shift register with parallel load, dord-selected direction and output-bit select.
// Build option AVR_SPI_SCKD_DORD_EN enables the LSB-first direction; without it the register is MSB-first only.
module avr_spi_sckd_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_scki,
  input  logic              rst_sckd_n,
  input  logic              dord,
  input  logic              load,
  input  logic              shift,
  input  logic              sin,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] q_shift,
  output logic              out_bit
);

  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] q_nx;

  // A load combined with a shift yields the loaded word already advanced by one bit.
  always_comb begin
    base = load ? d : q;
`ifdef AVR_SPI_SCKD_DORD_EN
    q_shift = dord ? {sin, base[DATA_W-1:1]} : {base[DATA_W-2:0], sin};
    out_bit = dord ? q[0] : q[DATA_W-1];
`else
    q_shift = {base[DATA_W-2:0], sin};
    out_bit = q[DATA_W-1];
`endif
    q_nx = shift ? q_shift : base;
  end

`ifndef AVR_SPI_SCKD_DORD_EN
  logic unused_dord;
  assign unused_dord = dord;
`endif

  always_ff @(posedge clk_scki or negedge rst_sckd_n) begin
    if (!rst_sckd_n) q <= '0;
    else             q <= q_nx;
  end

endmodule

// File: rtl/avr_spi_sckd_frame.sv
// SCK-domain slave shift engine: MOSI/MISO shifting, RX/TX word handshakes, underrun/overrun flags.
// Build option AVR_SPI_SCKD_DORD_EN honours spcr.dord (LSB first); otherwise MSB first only.
//
// state | meaning
// IDLE  | disabled or just out of reset; an enabled edge is a frame-start edge
// FIRST | previous frame done; next edge samples bit 0 and loads the TX word
// SHIFT | bits 1..DATA_W-1 of the current frame
module avr_spi_sckd_frame
  import avr_spi_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] UNDER_FILL = '1,
  localparam int               CNT_W      = $clog2(DATA_W)
) (
  input  logic              clk_scki,
  input  logic              rst_sckd_n,
  input  spcr_t             core_sckd_spcr,
  input  logic              mosii,
  input  logic [DATA_W-1:0] core_sckd_tx_data,
  input  logic              core_sckd_tx_tog,
  input  logic              core_sckd_rx_ack,
  output logic              sckd_core_tx_ack,
  output logic [DATA_W-1:0] sckd_core_rx_data,
  output logic              sckd_core_rx_tog,
  output logic              sckd_core_ovr_tog,
  output logic              sckd_core_und_tog,
  output logic [CNT_W-1:0]  sckd_core_bitcnt,
  output logic              misoo_next
);

  sckd_frame_state_e state_q, state_nx;

  logic                      en;
  logic                      dord;
  logic                      frame_start;
  logic                      tx_load;
  logic                      last_bit;
  logic                      tx_pending;
  logic [DATA_W-1:0]         load_word;
  logic [SPI_DATA_W_MAX-1:0] load_word_ext;
  logic [DATA_W-1:0]         rx_q;
  logic [DATA_W-1:0]         rx_shift;
  logic                      tx_out_bit;
  logic                      rx_out_unused;
  logic [DATA_W-1:0]         tx_q_unused;
  logic [DATA_W-1:0]         tx_shift_unused;

  assign en = core_sckd_spcr.spe & ~core_sckd_spcr.mstr;

`ifdef AVR_SPI_SCKD_DORD_EN
  assign dord = core_sckd_spcr.dord;
  logic unused_cfg;
  assign unused_cfg = core_sckd_spcr.cpha;
`else
  assign dord = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{core_sckd_spcr.cpha, core_sckd_spcr.dord};
`endif

  assign last_bit   = (sckd_core_bitcnt == CNT_W'(DATA_W - 1));
  assign tx_pending = (core_sckd_tx_tog != sckd_core_tx_ack);
  assign load_word  = tx_pending ? core_sckd_tx_data : UNDER_FILL;

  always_comb begin
    state_nx    = state_q;
    frame_start = 1'b0;
    tx_load     = 1'b0;
    case (state_q)
      IDLE, FIRST: begin
        frame_start = 1'b1;
        tx_load     = en;
        state_nx    = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nx = FIRST;
      end
      default: state_nx = IDLE;
    endcase
    if (!en) state_nx = IDLE;
  end

  always_ff @(posedge clk_scki or negedge rst_sckd_n) begin
    if (!rst_sckd_n) state_q <= IDLE;
    else             state_q <= state_nx;
  end

  always_ff @(posedge clk_scki or negedge rst_sckd_n) begin
    if (!rst_sckd_n) begin
      sckd_core_bitcnt  <= '0;
      sckd_core_rx_data <= '0;
      sckd_core_rx_tog  <= 1'b0;
      sckd_core_ovr_tog <= 1'b0;
      sckd_core_und_tog <= 1'b0;
      sckd_core_tx_ack  <= 1'b0;
    end else if (en) begin
      sckd_core_bitcnt <= last_bit ? '0 : sckd_core_bitcnt + 1'b1;
      if (last_bit) begin
        sckd_core_rx_data <= rx_shift;
        sckd_core_rx_tog  <= ~sckd_core_rx_tog;
        // Overrun uses the ack as seen before this edge; rx_data is still overwritten.
        if (sckd_core_rx_tog != core_sckd_rx_ack) sckd_core_ovr_tog <= ~sckd_core_ovr_tog;
      end
      if (tx_load) begin
        if (tx_pending) sckd_core_tx_ack  <= core_sckd_tx_tog;
        else            sckd_core_und_tog <= ~sckd_core_und_tog;
      end
    end else begin
      sckd_core_bitcnt <= '0;
    end
  end

  avr_spi_sckd_shreg #(.DATA_W(DATA_W)) u_rx_shreg (
    .clk_scki   (clk_scki),
    .rst_sckd_n (rst_sckd_n),
    .dord       (dord),
    .load       (1'b0),
    .shift      (en),
    .sin        (mosii),
    .d          ('0),
    .q          (rx_q),
    .q_shift    (rx_shift),
    .out_bit    (rx_out_unused)
  );

  avr_spi_sckd_shreg #(.DATA_W(DATA_W)) u_tx_shreg (
    .clk_scki   (clk_scki),
    .rst_sckd_n (rst_sckd_n),
    .dord       (dord),
    .load       (tx_load),
    .shift      (en),
    .sin        (1'b0),
    .d          (load_word),
    .q          (tx_q_unused),
    .q_shift    (tx_shift_unused),
    .out_bit    (tx_out_bit)
  );

  logic unused_rx_q;
  assign unused_rx_q = ^rx_q;

  // Before the frame-start edge the shifter is not loaded yet, so the first bit comes from the word about to be loaded.
  always_comb begin
    load_word_ext               = '0;
    load_word_ext[DATA_W-1:0]   = load_word;
    misoo_next = frame_start ? first_bit(load_word_ext, dord, DATA_W) : tx_out_bit;
  end

endmodule

// File: tb/tb_avr_spi_sckd_frame.sv
// Self-checking bench for avr_spi_sckd_frame (DATA_W=8) against a frame-level reference model.
module tb_avr_spi_sckd_frame;
  import avr_spi_pkg::*;

  localparam int DW = 8;

  logic          clk_scki;
  logic          rst_sckd_n;
  spcr_t         spcr;
  logic          mosii;
  logic [DW-1:0] tx_data;
  logic          tx_tog;
  logic          rx_ack;
  logic          tx_ack;
  logic [DW-1:0] rx_data;
  logic          rx_tog;
  logic          ovr_tog;
  logic          und_tog;
  logic [2:0]    bitcnt;
  logic          misoo_next;

  avr_spi_sckd_frame #(.DATA_W(DW)) dut (
    .clk_scki          (clk_scki),
    .rst_sckd_n        (rst_sckd_n),
    .core_sckd_spcr    (spcr),
    .mosii             (mosii),
    .core_sckd_tx_data (tx_data),
    .core_sckd_tx_tog  (tx_tog),
    .core_sckd_rx_ack  (rx_ack),
    .sckd_core_tx_ack  (tx_ack),
    .sckd_core_rx_data (rx_data),
    .sckd_core_rx_tog  (rx_tog),
    .sckd_core_ovr_tog (ovr_tog),
    .sckd_core_und_tog (und_tog),
    .sckd_core_bitcnt  (bitcnt),
    .misoo_next        (misoo_next)
  );

  initial clk_scki = 1'b0;
  always #5 clk_scki = ~clk_scki;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic          m_tx_ack, m_rx_tog, m_ovr, m_und;
  logic [DW-1:0] m_rx_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx_ack  = 1'b0;
    m_rx_tog  = 1'b0;
    m_ovr     = 1'b0;
    m_und     = 1'b0;
    m_rx_data = '0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rx_data"}, 32'(rx_data), 32'(m_rx_data));
    check({tag, ".rx_tog"},  32'(rx_tog),  32'(m_rx_tog));
    check({tag, ".ovr_tog"}, 32'(ovr_tog), 32'(m_ovr));
    check({tag, ".und_tog"}, 32'(und_tog), 32'(m_und));
    check({tag, ".tx_ack"},  32'(tx_ack),  32'(m_tx_ack));
  endtask

  task automatic offer_tx(input logic [DW-1:0] w);
    tx_data = w;
    tx_tog  = ~tx_tog;
  endtask

  // Runs nbits bit-times of a frame; called just after a negedge, returns just after a negedge.
  task automatic run_frame(input string tag, input logic [DW-1:0] mosi_w, input int nbits,
                           input logic dord_v);
    logic [DW-1:0] tx_w;
    int idx;
    spcr.dord = dord_v;
    if (tx_tog != m_tx_ack) begin
      tx_w     = tx_data;
      m_tx_ack = tx_tog;
    end else begin
      tx_w  = '1;
      m_und = ~m_und;
    end
    for (int i = 0; i < nbits; i++) begin
      idx = dord_v ? i : DW - 1 - i;
      #1;
      check({tag, ".misoo"},  32'(misoo_next), 32'(tx_w[idx]));
      check({tag, ".bitcnt"}, 32'(bitcnt),     32'(i));
      mosii = mosi_w[idx];
      @(negedge clk_scki);
    end
    if (nbits == DW) begin
      if (m_rx_tog != rx_ack) m_ovr = ~m_ovr;
      m_rx_tog  = ~m_rx_tog;
      m_rx_data = mosi_w;
      #1;
      check({tag, ".bitcnt_end"}, 32'(bitcnt), 32'(0));
      check_state(tag);
    end
  endtask

  initial begin
    logic dord_r;
    rst_sckd_n = 1'b0;
    spcr       = '{spe: 1'b1, mstr: 1'b0, dord: 1'b0, cpha: 1'b0};
    mosii      = 1'b0;
    tx_data    = '0;
    tx_tog     = 1'b0;
    rx_ack     = 1'b0;
    model_reset();
    @(negedge clk_scki);
    @(negedge clk_scki);
    #1;
    check("rst.bitcnt", 32'(bitcnt), 32'(0));
    check("rst.misoo_underfill", 32'(misoo_next), 32'(1));
    check_state("rst");
    rst_sckd_n = 1'b1;

    // reset mid-frame: word consumed at bit 0, reset clears ack so it is pending again
    offer_tx(8'h5A);
    run_frame("rstmid", 8'hC3, 5, 1'b0);
    rst_sckd_n = 1'b0;
    rx_ack     = 1'b0;
    model_reset();
    #1;
    check("rstmid.bitcnt", 32'(bitcnt), 32'(0));
    check_state("rstmid");
    rst_sckd_n = 1'b1;
    run_frame("resend", 8'h96, DW, 1'b0);

    // basic frame: tx 0xA5 out, 0x3C in
    rx_ack = m_rx_tog;
    offer_tx(8'hA5);
    run_frame("basic", 8'h3C, DW, 1'b0);

    // underrun: nothing offered
    rx_ack = m_rx_tog;
    run_frame("under", 8'hE1, DW, 1'b0);

    // overrun: second frame without rx_ack
    rx_ack = m_rx_tog;
    run_frame("ovr1", 8'h11, DW, 1'b0);
    run_frame("ovr2", 8'h22, DW, 1'b0);

    // drop spe mid-frame, then a clean frame
    rx_ack = m_rx_tog;
    offer_tx(8'h3E);
    run_frame("abort", 8'hFF, 4, 1'b0);
    spcr.spe = 1'b0;
    @(negedge clk_scki);
    #1;
    check("abort.bitcnt", 32'(bitcnt), 32'(0));
    check_state("abort");
    spcr.spe = 1'b1;
    offer_tx(8'h71);
    run_frame("reen", 8'h4D, DW, 1'b0);

`ifdef AVR_SPI_SCKD_DORD_EN
    rx_ack = m_rx_tog;
    offer_tx(8'h81);
    run_frame("lsb", 8'h34, DW, 1'b1);
`endif

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(1, 0) == 1 && tx_tog == m_tx_ack) offer_tx(8'($urandom));
      if ($urandom_range(3, 0) != 0) rx_ack = m_rx_tog;
`ifdef AVR_SPI_SCKD_DORD_EN
      dord_r = 1'($urandom_range(1, 0));
`else
      dord_r = 1'b0;
`endif
      run_frame("rand", 8'($urandom), DW, dord_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
